tpu_tile_sequencer: RTL and testbench
=====================================

TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
REQ-001 Parameter AWIDTH, default 10, is the width of the matrix SRAM address.
REQ-002 Parameter ADDR_STRIDE_WIDTH, default 8, is the width of each address stride.
REQ-003 clk  in  1  is the single clock; all logic is on its rising edge.
REQ-004 reset  in  1  is a synchronous, active-high reset.
REQ-005 start_tpu  in  1  is a level run request from the config block.
REQ-006 enable_matmul, enable_norm, enable_pool, enable_activation  in  1 each  are stage enables.
REQ-007 address_mat_a/b/c  in  AWIDTH  are the base addresses.
REQ-008 address_stride_a/b/c  in  ADDR_STRIDE_WIDTH  are the per-tile address increments.
REQ-009 num_matrices_A, num_matrices_B  in  32  are the tile counts along rows and columns.
REQ-010 done_mat_mul  in  1  is the matmul completion level.
REQ-011 done_post  in  1  is the norm/pool/activation completion level.
REQ-012 start_mat_mul  out  1  is the matmul run level.
REQ-013 start_post  out  1  is the post-processing run level.
REQ-014 pe_reset  out  1  is a one-cycle PE clear pulse.
REQ-015 a_addr, b_addr, c_addr  out  AWIDTH  are the current tile addresses.
REQ-016 tile_i, tile_j  out  32  are the current tile indices.
REQ-017 done_tpu  out  1  is the run-complete level.
REQ-018 busy  out  1  is high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, PE_CLR, MATMUL, POST, NEXT and DONE.
REQ-020 In IDLE with start_tpu=1: if num_matrices_A=0 or num_matrices_B=0, or all four enables are 0, the FSM SHALL go to DONE; otherwise it SHALL load tile_i=tile_j=0, a_addr=address_mat_a, b_addr=address_mat_b, c_addr=address_mat_c, and go to PE_CLR.
REQ-021 PE_CLR SHALL last exactly one cycle with pe_reset=1. It SHALL then go to MATMUL if enable_matmul=1, else to POST.
REQ-022 In MATMUL, start_mat_mul SHALL be 1. done_mat_mul is sampled every MATMUL cycle, including the first. On done_mat_mul=1: go to POST if any of norm/pool/activation is enabled, else go to NEXT.
REQ-023 In POST, start_post SHALL be 1 until done_post=1, then the FSM SHALL go to NEXT.
REQ-024 done_mat_mul and done_post SHALL be ignored outside MATMUL and POST respectively.
REQ-025 NEXT SHALL last one cycle and advance the tile:
  - last tile (tile_i=num_matrices_A-1 and tile_j=num_matrices_B-1): go to DONE;
  - else if tile_j=num_matrices_B-1: tile_j=0, tile_i+1, b_addr=address_mat_b, a_addr+=stride_a, then PE_CLR;
  - else: tile_j+1, b_addr+=stride_b, then PE_CLR;
  - c_addr+=stride_c in all non-final cases.
REQ-026 Address arithmetic SHALL be unsigned with the stride zero-extended, and SHALL wrap modulo 2^AWIDTH.
REQ-027 a_addr, b_addr, c_addr, tile_i and tile_j SHALL be registered and SHALL remain stable for as long as start_mat_mul or start_post is 1.
REQ-028 In DONE, done_tpu SHALL be 1. When start_tpu=0 the FSM SHALL go to IDLE, and done_tpu SHALL be 0 the following cycle.
REQ-029 start_tpu deasserting in any state other than IDLE or DONE SHALL be ignored; the run completes.
REQ-030 Configuration inputs SHALL be sampled only in IDLE (bases) and in PE_CLR/NEXT (counts, strides, enables); software holds them static during a run.
REQ-031 Latency from start_tpu rising in IDLE to start_mat_mul=1 SHALL be 2 cycles (IDLE→PE_CLR→MATMUL).

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE from any state, including mid-run, with every output 0 and all addresses and indices 0.
REQ-033 The first run after reset SHALL behave identically to a fresh run.

Structure
REQ-034 State encodings and the AWIDTH/ADDR_STRIDE_WIDTH defaults SHALL live in the shared defines file used by the config block.
REQ-035 The block SHALL be a single module with no sub-modules. Address and tile advance SHALL be coded in one registered always block beside the FSM.

Verification
REQ-036 Scenario — 2×2 tiles: A=2, B=2, bases 0/100/200, strides 8/8/16, matmul+activation enabled, done_mat_mul and done_post each 5 cycles after start. Required: (a,b,c) = (0,100,200), (0,108,216), (8,100,232), (8,108,248); 4 pe_reset pulses; then done_tpu=1.
REQ-037 Scenario — zero tiles: num_matrices_A=0 with start_tpu=1. Required: DONE next cycle; start_mat_mul, start_post and pe_reset never asserted.
REQ-038 Scenario — matmul only: 1 tile, only enable_matmul=1. Required: start_post never asserted; done_tpu rises 2 cycles after done_mat_mul.
REQ-039 Scenario — wrap-around: AWIDTH=10, address_mat_c=1020, stride_c=8, A=1, B=2. Required: second tile c_addr=4.
REQ-040 Scenario — reset mid-run: reset pulsed during MATMUL of tile 1. Required: all outputs 0 next cycle; a restart begins at tile 0 with the base addresses.
REQ-041 Scenario — early release: start_tpu dropped during POST; done_mat_mul held high in NEXT. Required: the run completes, the spurious done is ignored, done_tpu asserts, then IDLE.

Source files
------------

// File: rtl/tpu_tile_sequencer_pkg.sv
// Shared definitions for the TPU tile sequencer and the config block.
// This package holds the state encoding and the default address and stride widths.
package tpu_tile_sequencer_pkg;

    localparam int AWIDTH_DEFAULT            = 10;
    localparam int ADDR_STRIDE_WIDTH_DEFAULT = 8;

    // Sequencer states. The encoding is fixed so that debug tooling and the
    // config block decode the same values.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PE_CLR = 3'd1,
        ST_MATMUL = 3'd2,
        ST_POST   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } tile_state_t;

    // True when any post-processing stage is requested.
    function automatic logic post_enabled(input logic norm, input logic pool,
                                          input logic act);
        return norm | pool | act;
    endfunction

endpackage

// File: rtl/tpu_tile_sequencer.sv
// Walks a num_matrices_A x num_matrices_B grid of tiles. For each tile it
// clears the PEs, then runs matmul and/or post-processing, and finally
// advances the tile indices and SRAM addresses.
//
// Handshake: start_mat_mul / start_post are run levels. Each one stays high
// for every cycle the FSM spends in MATMUL / POST. The matching done level is
// sampled on each of those cycles, the first one included. Any done seen on
// another cycle is ignored. Tile addresses and indices do not change while
// either run level is high.
module tpu_tile_sequencer
    import tpu_tile_sequencer_pkg::*;
#(
    parameter int AWIDTH            = AWIDTH_DEFAULT,
    parameter int ADDR_STRIDE_WIDTH = ADDR_STRIDE_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_tpu,
    input  logic                         enable_matmul,
    input  logic                         enable_norm,
    input  logic                         enable_pool,
    input  logic                         enable_activation,
    input  logic [AWIDTH-1:0]            address_mat_a,
    input  logic [AWIDTH-1:0]            address_mat_b,
    input  logic [AWIDTH-1:0]            address_mat_c,
    input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_a,
    input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_b,
    input  logic [ADDR_STRIDE_WIDTH-1:0] address_stride_c,
    input  logic [31:0]                  num_matrices_A,
    input  logic [31:0]                  num_matrices_B,
    input  logic                         done_mat_mul,
    input  logic                         done_post,
    output logic                         start_mat_mul,
    output logic                         start_post,
    output logic                         pe_reset,
    output logic [AWIDTH-1:0]            a_addr,
    output logic [AWIDTH-1:0]            b_addr,
    output logic [AWIDTH-1:0]            c_addr,
    output logic [31:0]                  tile_i,
    output logic [31:0]                  tile_j,
    output logic                         done_tpu,
    output logic                         busy,
    output tile_state_t                  fsm_state
);

    tile_state_t state;
    tile_state_t state_next;

    logic any_post;
    logic run_empty;
    logic last_col;
    logic last_row;

    assign any_post  = post_enabled(enable_norm, enable_pool, enable_activation);
    assign run_empty = (num_matrices_A == 32'd0) || (num_matrices_B == 32'd0) ||
                       !(enable_matmul || any_post);
    assign last_col  = (tile_j == num_matrices_B - 32'd1);
    assign last_row  = (tile_i == num_matrices_A - 32'd1);
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. All outputs are decoded from the current state only.
    always_comb begin
        state_next    = state;
        start_mat_mul = 1'b0;
        start_post    = 1'b0;
        pe_reset      = 1'b0;
        done_tpu      = 1'b0;
        busy          = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_tpu) begin
                    state_next = run_empty ? ST_DONE : ST_PE_CLR;
                end
            end
            ST_PE_CLR: begin
                pe_reset   = 1'b1;
                state_next = enable_matmul ? ST_MATMUL : ST_POST;
            end
            ST_MATMUL: begin
                start_mat_mul = 1'b1;
                if (done_mat_mul) begin
                    state_next = any_post ? ST_POST : ST_NEXT;
                end
            end
            ST_POST: begin
                start_post = 1'b1;
                if (done_post) begin
                    state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_next = (last_row && last_col) ? ST_DONE : ST_PE_CLR;
            end
            ST_DONE: begin
                done_tpu = 1'b1;
                if (!start_tpu) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Tile index and address registers. They load in IDLE and advance in NEXT.
    // Addresses wrap modulo 2^AWIDTH, and the strides are zero-extended.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_addr <= '0;
            b_addr <= '0;
            c_addr <= '0;
            tile_i <= '0;
            tile_j <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_tpu && !run_empty) begin
                        a_addr <= address_mat_a;
                        b_addr <= address_mat_b;
                        c_addr <= address_mat_c;
                        tile_i <= '0;
                        tile_j <= '0;
                    end
                end
                ST_NEXT: begin
                    if (!(last_row && last_col)) begin
                        c_addr <= c_addr + AWIDTH'(address_stride_c);
                        if (last_col) begin
                            tile_j <= '0;
                            tile_i <= tile_i + 32'd1;
                            b_addr <= address_mat_b;
                            a_addr <= a_addr + AWIDTH'(address_stride_a);
                        end else begin
                            tile_j <= tile_j + 32'd1;
                            b_addr <= b_addr + AWIDTH'(address_stride_b);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Testbench for tpu_tile_sequencer. Expected tile records come from a plain
// grid-walk model. A monitor pops and compares a record on every PE clear,
// and a responder process drives done_mat_mul / done_post.
module tb_tpu_tile_sequencer;
    import tpu_tile_sequencer_pkg::*;

    localparam int AW = 10;
    localparam int SW = 8;
    localparam int W  = 96;   // {tile_i, tile_j, a, b, c, mm_expected, post_expected}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          start_tpu, en_mm, en_norm, en_pool, en_act;
    logic [AW-1:0] base_a, base_b, base_c;
    logic [SW-1:0] stride_a, stride_b, stride_c;
    logic [31:0]   num_a, num_b;
    logic          done_mat_mul, done_post;
    logic          start_mat_mul, start_post, pe_reset, done_tpu, busy;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [31:0]   tile_i, tile_j;
    tile_state_t   fsm_state;

    tpu_tile_sequencer #(.AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .start_tpu(start_tpu),
        .enable_matmul(en_mm), .enable_norm(en_norm), .enable_pool(en_pool),
        .enable_activation(en_act),
        .address_mat_a(base_a), .address_mat_b(base_b), .address_mat_c(base_c),
        .address_stride_a(stride_a), .address_stride_b(stride_b),
        .address_stride_c(stride_c),
        .num_matrices_A(num_a), .num_matrices_B(num_b),
        .done_mat_mul(done_mat_mul), .done_post(done_post),
        .start_mat_mul(start_mat_mul), .start_post(start_post), .pe_reset(pe_reset),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
        .tile_i(tile_i), .tile_j(tile_j), .done_tpu(done_tpu), .busy(busy),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int exp_tiles;

    task automatic check_val(input string name, input logic [95:0] act,
                             input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h need %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: walk the tile grid in row-major order. Each address is
    // base + index*stride, reduced modulo 2^AW.
    task automatic build_expect();
        int unsigned a, b, c;
        logic mm, post;
        exp_tiles = 0;
        mm   = en_mm;
        post = en_norm | en_pool | en_act;
        if (num_a == 0 || num_b == 0 || !(mm || post)) return;
        for (int unsigned i = 0; i < num_a; i++) begin
            for (int unsigned j = 0; j < num_b; j++) begin
                a = (int'(base_a) + i * int'(stride_a)) % (1 << AW);
                b = (int'(base_b) + j * int'(stride_b)) % (1 << AW);
                c = (int'(base_c) + (i * num_b + j) * int'(stride_c)) % (1 << AW);
                exp_q.push_back({i, j, AW'(a), AW'(b), AW'(c), mm, post});
                exp_tiles++;
            end
        end
    endtask

    // ---------------- done responder ----------------
    int   mm_lat = 2, post_lat = 2;
    logic force_mm = 1'b0;
    int   mm_done_cyc = -1;

    initial begin
        int mm_cnt = 0;
        int post_cnt = 0;
        done_mat_mul = 1'b0;
        done_post    = 1'b0;
        forever begin
            @(negedge clk);
            if (start_mat_mul) begin
                done_mat_mul = force_mm || (mm_cnt >= mm_lat);
                if (done_mat_mul) mm_done_cyc = cyc;
                mm_cnt++;
            end else begin
                mm_cnt = 0;
                done_mat_mul = force_mm;
            end
            if (start_post) begin
                done_post = (post_cnt >= post_lat);
                post_cnt++;
            end else begin
                post_cnt = 0;
                done_post = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [W-1:0]  cur_rec;
    logic          tile_open = 1'b0;
    logic          saw_mm, saw_post;
    int            pe_seen = 0, mm_seen = 0, post_seen = 0;
    int            first_mm_cyc = -1;
    logic [AW-1:0] last_c;

    task automatic close_tile();
        if (tile_open) begin
            check_val("stage_flags", {saw_mm, saw_post}, cur_rec[1:0]);
            tile_open = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pe_reset) begin
                    close_tile();
                    pe_seen++;
                    last_c = c_addr;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pe_reset_unexpected: got pulse need none (t=%0t)", $time);
                    end else begin
                        cur_rec = exp_q.pop_front();
                        check_val("tile_record", {tile_i, tile_j, a_addr, b_addr, c_addr},
                                  cur_rec[W-1:2]);
                        tile_open = 1'b1;
                        saw_mm    = 1'b0;
                        saw_post  = 1'b0;
                    end
                end
                if (start_mat_mul) begin
                    if (mm_seen == 0) first_mm_cyc = cyc;
                    mm_seen++;
                    saw_mm = 1'b1;
                end
                if (start_post) begin
                    post_seen++;
                    saw_post = 1'b1;
                end
                if ((start_mat_mul || start_post) && tile_open) begin
                    check_val("tile_stable", {tile_i, tile_j, a_addr, b_addr, c_addr},
                              cur_rec[W-1:2]);
                end
                if (done_tpu) close_tile();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input int na, input int nb, input int ba, input int bb,
                           input int bc, input int sa, input int sb, input int sc,
                           input logic [3:0] en);
        num_a = na; num_b = nb;
        base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc);
        stride_a = SW'(sa); stride_b = SW'(sb); stride_c = SW'(sc);
        {en_mm, en_norm, en_pool, en_act} = en;
    endtask

    task automatic clear_counts();
        pe_seen = 0; mm_seen = 0; post_seen = 0;
        first_mm_cyc = -1; mm_done_cyc = -1;
    endtask

    // Wait (bounded) for done_tpu; returns the cycle it was seen or -1.
    task automatic wait_done(input string name, output int seen_cyc);
        seen_cyc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_tpu) begin
                seen_cyc = cyc;
                break;
            end
        end
        total++;
        if (seen_cyc < 0) begin
            bad++;
            $display("FAIL %s_timeout: got no done_tpu need done_tpu=1", name);
        end
    endtask

    // Full run with start_tpu held until done; checks bookkeeping and release.
    task automatic run_job(input string name, output int done_cyc, output int start_cyc);
        clear_counts();
        build_expect();
        start_cyc = cyc;
        start_tpu = 1'b1;
        wait_done(name, done_cyc);
        check_val({name, "_queue_empty"}, exp_q.size(), 0);
        check_val({name, "_pe_count"}, pe_seen, exp_tiles);
        if (!en_mm) check_val({name, "_no_matmul"}, mm_seen, 0);
        if (!(en_norm | en_pool | en_act)) check_val({name, "_no_post"}, post_seen, 0);
        start_tpu = 1'b0;
        @(negedge clk);
        check_val({name, "_release"}, {done_tpu, busy}, 2'b00);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dc, sc;
        reset = 1'b1;
        start_tpu = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {start_mat_mul, start_post, pe_reset, done_tpu, busy,
                   a_addr, b_addr, c_addr, tile_i, tile_j}, 0);
        check_val("reset_state", fsm_state, ST_IDLE);
        reset = 1'b0;
        @(negedge clk);

        // 2x2 grid, matmul + activation, both done levels 5 cycles after start.
        mm_lat = 5; post_lat = 5;
        set_cfg(2, 2, 0, 100, 200, 8, 8, 16, 4'b1001);
        run_job("grid2x2", dc, sc);
        check_val("grid2x2_latency", first_mm_cyc - sc, 2);
        check_val("grid2x2_last_c", last_c, 248);

        // Zero tiles: DONE on the next cycle with nothing started.
        clear_counts();
        set_cfg(0, 3, 5, 6, 7, 1, 1, 1, 4'b1111);
        start_tpu = 1'b1;
        @(negedge clk);
        check_val("zero_done_next", done_tpu, 1'b1);
        check_val("zero_nothing_run", {pe_seen[7:0], mm_seen[7:0], post_seen[7:0]}, 0);
        start_tpu = 1'b0;
        @(negedge clk);
        check_val("zero_release", {done_tpu, busy}, 2'b00);

        // Matmul only, single tile.
        mm_lat = 3;
        set_cfg(1, 1, 33, 44, 55, 1, 2, 3, 4'b1000);
        run_job("mm_only", dc, sc);
        check_val("mm_only_done_lat", dc - mm_done_cyc, 2);

        // c_addr wraps modulo 2^10.
        mm_lat = 1; post_lat = 1;
        set_cfg(1, 2, 0, 0, 1020, 4, 4, 8, 4'b1100);
        run_job("wrap", dc, sc);
        check_val("wrap_c", last_c, 4);

        // Reset during MATMUL of the second tile, then restart.
        mm_lat = 4; post_lat = 2;
        set_cfg(2, 2, 10, 20, 30, 3, 5, 7, 4'b1010);
        clear_counts();
        build_expect();
        start_tpu = 1'b1;
        begin
            int found = 0;
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (start_mat_mul && tile_i == 0 && tile_j == 1) begin
                    found = 1;
                    break;
                end
            end
            check_val("reset_mid_reach", found, 1);
        end
        reset = 1'b1;
        start_tpu = 1'b0;
        exp_q.delete();
        tile_open = 1'b0;
        @(negedge clk);
        check_val("reset_mid_outputs",
                  {start_mat_mul, start_post, pe_reset, done_tpu, busy,
                   a_addr, b_addr, c_addr, tile_i, tile_j}, 0);
        reset = 1'b0;
        @(negedge clk);
        run_job("restart", dc, sc);

        // Early release during POST, with a spurious done_mat_mul held afterwards.
        mm_lat = 1; post_lat = 3;
        set_cfg(1, 1, 1, 2, 3, 1, 1, 1, 4'b1001);
        clear_counts();
        build_expect();
        start_tpu = 1'b1;
        begin
            int found = 0;
            for (int k = 0; k < 500; k++) begin
                @(negedge clk);
                if (start_post) begin
                    found = 1;
                    break;
                end
            end
            check_val("early_reach_post", found, 1);
        end
        start_tpu = 1'b0;
        force_mm = 1'b1;
        wait_done("early", dc);
        check_val("early_pe_count", pe_seen, 1);
        check_val("early_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check_val("early_idle", {done_tpu, busy, start_mat_mul}, 3'b000);
        force_mm = 1'b0;
        @(negedge clk);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            mm_lat = $urandom_range(0, 4);
            post_lat = $urandom_range(0, 4);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255),
                    4'($urandom_range(0, 15)));
            run_job("random", dc, sc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
